// File: rtl/ball_tick_scheduler.sv
// Game-update sequencer: programmable tick divider, frame-synced four-phase req/ack update sequence.
// Optional BALL_SINGLE_STEP_EN adds a `step` input that launches one sequence while paused.
module ball_tick_scheduler #(
   parameter int CLK_HZ       = 25_000_000,
   parameter int BASE_TICK_HZ = 10,
   parameter int DIV_W        = 22,
   parameter int TIMEOUT      = 1023,
   parameter int TO_W         = 10
) (
   input  logic        clk_25MHz,
   input  logic        reset,
   input  logic        run,
   input  logic [1:0]  speed,
   input  logic        frame_sync,
`ifdef BALL_SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        phase_req,
   output logic [1:0]  phase_id,
   input  logic        phase_ack,
   output logic        busy,
   output logic        tick_miss,
   output logic        timeout_err,
   output logic [15:0] tick_cnt
);

   localparam int PERIOD = CLK_HZ / BASE_TICK_HZ;
   localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_REQ  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] reload;
   logic [1:0]       state;
   logic [1:0]       pid;
   logic [TO_W-1:0]  to_cnt;
   logic             stepped;
   logic             tick;
   logic             step_go;
   logic             to_hit;

   // speed only matters at the reload point, so a mid-period change waits for the next period
   assign reload = DIV_W'((PERIOD >> speed) - 1);
   assign tick   = run && (div == '0);
   assign to_hit = (state == S_REQ) && !phase_ack && (to_cnt == TO_LAST);

`ifdef BALL_SINGLE_STEP_EN
   assign step_go = step && !run;
`else
   assign step_go = 1'b0;
`endif

   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         div      <= RELOAD0;
         state    <= S_IDLE;
         pid      <= 2'd0;
         to_cnt   <= '0;
         tick_cnt <= 16'd0;
         stepped  <= 1'b0;
      end else begin
         if (run)
            div <= tick ? reload : div - 1'b1;
         case (state)
            S_IDLE: begin
               to_cnt <= '0;
               pid    <= 2'd0;
               if (tick || step_go) begin
                  state   <= S_WAIT;
                  stepped <= step_go;
               end
            end
            S_WAIT: begin
               // a stepped sequence is launched while paused, so pause must not cancel it
               if (!run && !stepped)
                  state <= S_IDLE;
               else if (frame_sync) begin
                  state  <= S_REQ;
                  pid    <= 2'd0;
                  to_cnt <= '0;
               end
            end
            S_REQ: begin
               if (phase_ack) begin
                  to_cnt <= '0;
                  if (pid == 2'd3) begin
                     state    <= S_IDLE;
                     pid      <= 2'd0;
                     tick_cnt <= tick_cnt + 16'd1;
                  end else begin
                     state <= S_GAP;
                     pid   <= pid + 2'd1;
                  end
               end else if (to_hit) begin
                  state  <= S_IDLE;
                  pid    <= 2'd0;
                  to_cnt <= '0;
               end else
                  to_cnt <= to_cnt + 1'b1;
            end
            S_GAP: begin
               to_cnt <= '0;
               state  <= S_REQ;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign phase_req   = (state == S_REQ);
   assign phase_id    = pid;
   assign busy        = (state != S_IDLE);
   assign tick_miss   = !reset && tick && (state != S_IDLE);
   assign timeout_err = !reset && to_hit;

endmodule

// File: tb/tb_ball_tick_scheduler.sv
// Directed bench for ball_tick_scheduler (PERIOD=100, TIMEOUT=16); cycle 1 is the first cycle after reset.
module tb_ball_tick_scheduler;

   logic        clk_25MHz = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [1:0]  speed = 2'd0;
   logic        frame_sync = 1'b0;
   logic        phase_ack = 1'b0;
`ifdef BALL_SINGLE_STEP_EN
   logic        step = 1'b0;
`endif
   logic        phase_req;
   logic [1:0]  phase_id;
   logic        busy;
   logic        tick_miss;
   logic        timeout_err;
   logic [15:0] tick_cnt;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #10 clk_25MHz = ~clk_25MHz;

   ball_tick_scheduler #(
      .CLK_HZ(1000), .BASE_TICK_HZ(10), .DIV_W(22), .TIMEOUT(16), .TO_W(10)
   ) dut (
      .clk_25MHz(clk_25MHz), .reset(reset), .run(run), .speed(speed),
      .frame_sync(frame_sync),
`ifdef BALL_SINGLE_STEP_EN
      .step(step),
`endif
      .phase_req(phase_req), .phase_id(phase_id), .phase_ack(phase_ack),
      .busy(busy), .tick_miss(tick_miss), .timeout_err(timeout_err),
      .tick_cnt(tick_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic nxt();
      @(posedge clk_25MHz);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) nxt();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nxt();
      nxt();
      reset = 1'b0;
      cyc = 1;
   endtask

   // called in the first REQ cycle of a phase; acks after dly extra cycles
   task automatic phase(input int id, input int dly, input bit last);
      chk("req", phase_req, 1);
      chk("pid", phase_id, id);
      repeat (dly) nxt();
      chk("req_held", phase_req, 1);
      chk("pid_held", phase_id, id);
      phase_ack = 1'b1;
      nxt();
      phase_ack = 1'b0;
      if (!last) begin
         chk("gap_req", phase_req, 0);
         chk("gap_pid", phase_id, id + 1);
         chk("gap_busy", busy, 1);
         nxt();
      end else begin
         chk("end_busy", busy, 0);
         chk("end_req", phase_req, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // basic sequence: tick at 100, frame_sync 3 cycles later, acks 2 cycles after req
      run = 1'b1;
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_req", phase_req, 0);
      chk("rst_pid", phase_id, 0);
      chk("rst_cnt", tick_cnt, 0);
      chk("rst_miss", tick_miss, 0);
      chk("rst_to", timeout_err, 0);
      go_to(100);
      chk("pre_tick_busy", busy, 0);
      chk("idle_tick_nomiss", tick_miss, 0);
      nxt();
      chk("wait_busy", busy, 1);
      chk("wait_req", phase_req, 0);
      go_to(103);
      frame_sync = 1'b1;
      nxt();
      frame_sync = 1'b0;
      phase(0, 2, 0);
      phase(1, 2, 0);
      phase(2, 2, 0);
      phase(3, 2, 1);
      chk("seq_cnt", tick_cnt, 1);
      chk("seq_end_cyc", cyc, 119);

      // reset mid-sequence at phase 2, single-cycle acks
      go_to(200);
      chk("t2_busy_idle", busy, 0);
      nxt();
      frame_sync = 1'b1;
      nxt();
      frame_sync = 1'b0;
      phase(0, 0, 0);
      phase(1, 0, 0);
      chk("mid_pid2", phase_id, 2);
      reset = 1'b1;
      nxt();
      chk("rst_mid_req", phase_req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cnt", tick_cnt, 0);
      chk("rst_mid_to", timeout_err, 0);
      reset = 1'b0;
      cyc = 1;
      go_to(100);
      chk("rst_mid_pre", busy, 0);
      nxt();
      chk("rst_mid_tick", busy, 1);

      // same-cycle frame_sync ignored, then timeout in phase 0
      do_reset();
      go_to(100);
      frame_sync = 1'b1;
      nxt();
      chk("fs_same_ignored", phase_req, 0);
      chk("fs_wait_busy", busy, 1);
      nxt();
      frame_sync = 1'b0;
      chk("to_req", phase_req, 1);
      go_to(116);
      chk("to_early", timeout_err, 0);
      nxt();
      chk("to_pulse", timeout_err, 1);
      chk("to_req_last", phase_req, 1);
      nxt();
      chk("to_clear", timeout_err, 0);
      chk("to_req_off", phase_req, 0);
      chk("to_busy", busy, 0);
      chk("to_cnt", tick_cnt, 0);

      // speed change mid-period
      do_reset();
      go_to(50);
      speed = 2'd2;
      go_to(124);
      chk("spd_124", tick_miss, 0);
      nxt();
      chk("spd_125", tick_miss, 1);
      go_to(149);
      chk("spd_149", tick_miss, 0);
      nxt();
      chk("spd_150", tick_miss, 1);
      nxt();
      chk("spd_151", tick_miss, 0);
      speed = 2'd0;

      // frame_sync held off: dropped ticks while waiting
      do_reset();
      go_to(199);
      chk("drop_199", tick_miss, 0);
      nxt();
      chk("drop_200", tick_miss, 1);
      chk("drop_busy", busy, 1);
      go_to(300);
      chk("drop_300", tick_miss, 1);
      go_to(351);
      chk("drop_still_wait", phase_req, 0);
      frame_sync = 1'b1;
      nxt();
      frame_sync = 1'b0;
      chk("late_fs_req", phase_req, 1);
      chk("late_fs_pid", phase_id, 0);

      // pause cancels WAIT_FRAME (beats frame_sync), divider holds while paused
      do_reset();
      go_to(102);
      chk("cancel_pre", busy, 1);
      run = 1'b0;
      frame_sync = 1'b1;
      nxt();
      frame_sync = 1'b0;
      chk("cancel_busy", busy, 0);
      chk("cancel_req", phase_req, 0);
      chk("cancel_to", timeout_err, 0);
      go_to(252);
      chk("paused_busy", busy, 0);
      run = 1'b1;
      go_to(350);
      chk("hold_pre", busy, 0);
      nxt();
      chk("hold_tick", busy, 1);

`ifdef BALL_SINGLE_STEP_EN
      // single step while paused runs one full sequence
      run = 1'b0;
      do_reset();
      go_to(10);
      step = 1'b1;
      nxt();
      step = 1'b0;
      chk("step_busy", busy, 1);
      frame_sync = 1'b1;
      nxt();
      frame_sync = 1'b0;
      phase(0, 1, 0);
      phase(1, 1, 0);
      phase(2, 1, 0);
      phase(3, 1, 1);
      chk("step_cnt", tick_cnt, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
